// File: rtl/dsi_pkg.sv
// Shared types and constants for the D-PHY lane sequencer.
// Lane drive encoding and the state list live here so lanes and FSM agree.
package dsi_pkg;

  typedef enum logic [2:0] {
    ST_DISABLED, ST_IDLE, ST_HS_RQST, ST_HS_PREP,
    ST_HS_ZERO, ST_HS_ACTIVE, ST_HS_TRAIL, ST_HS_EXIT
  } dsi_lane_state_t;

  // LP levels as {p, n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  localparam int T_LPX      = 5;
  localparam int T_HS_PREP  = 5;
  localparam int T_HS_ZERO  = 10;
  localparam int T_HS_TRAIL = 8;
  localparam int T_HS_EXIT  = 10;

  typedef struct packed {
    logic p;
    logic n;
    logic oe;
    logic hs;
  } lane_drv_t;

  function automatic logic is_timed(dsi_lane_state_t st);
    return st inside {ST_HS_RQST, ST_HS_PREP, ST_HS_ZERO, ST_HS_TRAIL, ST_HS_EXIT};
  endfunction

  // Masked-off lanes (act=0) park at LP-11 with the buffer enabled.
  function automatic lane_drv_t lane_drive(dsi_lane_state_t st, logic act);
    lane_drv_t d;
    d = '{p: LP11[1], n: LP11[0], oe: 1'b1, hs: 1'b0};
    case (st)
      ST_DISABLED: d.oe = 1'b0;
      ST_HS_RQST:  if (act) {d.p, d.n} = LP01;
      ST_HS_PREP:  if (act) {d.p, d.n} = LP00;
      ST_HS_ZERO, ST_HS_ACTIVE, ST_HS_TRAIL:
        if (act) begin
          d.oe = 1'b0;
          d.hs = 1'b1;
        end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dsi_dwell_timer.sv
// Shared dwell down-counter: load on state entry, done while the count is zero,
// so a state loaded with N lasts N+1 cycles.
module dsi_dwell_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - CNT_W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/dsi_lane_seq_multi.sv
// LP/HS burst sequencer for LANES D-PHY lanes with programmable dwells.
// Optional HS_ACTIVE watchdog: define DSI_LANE_HS_WDT_EN.
module dsi_lane_seq_multi
  import dsi_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNT_W = 8,
  parameter int WDT_W = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             lines_enable,
  input  logic             start_rqst,
  input  logic             fin_rqst,
  input  logic [LANES-1:0] lane_mask,
  input  logic [CNT_W-1:0] cfg_t_lpx,
  input  logic [CNT_W-1:0] cfg_t_prep,
  input  logic [CNT_W-1:0] cfg_t_zero,
  input  logic [CNT_W-1:0] cfg_t_trail,
  input  logic [CNT_W-1:0] cfg_t_exit,
  input  logic [WDT_W-1:0] cfg_t_wdt,
  input  logic             hs_fin_ack,
  output logic             hs_start,
  output logic             hs_fin,
  output logic [LANES-1:0] hs_en,
  output logic [LANES-1:0] lp_p,
  output logic [LANES-1:0] lp_n,
  output logic [LANES-1:0] lp_oe,
  output logic             busy,
  output logic             err_wdt
);

  dsi_lane_state_t state_q, state_nxt;
  logic             dwell_done, go, wdt_to, fin_q, fin_nxt;
  logic [CNT_W-1:0] lpx_s, prep_s, zero_s, trail_s, exit_s, load_val;
  logic [LANES-1:0] mask_s, mask_nxt;
  lane_drv_t [LANES-1:0] drv_nxt;

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_DISABLED:  if (lines_enable) state_nxt = ST_IDLE;
      ST_IDLE:      if (!lines_enable) state_nxt = ST_DISABLED;
                    else if (start_rqst) state_nxt = ST_HS_RQST;
      ST_HS_RQST:   if (dwell_done) state_nxt = ST_HS_PREP;
      ST_HS_PREP:   if (dwell_done) state_nxt = ST_HS_ZERO;
      ST_HS_ZERO:   if (dwell_done) state_nxt = ST_HS_ACTIVE;
      ST_HS_ACTIVE: if (hs_fin_ack || wdt_to) state_nxt = ST_HS_TRAIL;
      ST_HS_TRAIL:  if (dwell_done) state_nxt = ST_HS_EXIT;
      ST_HS_EXIT:   if (dwell_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_DISABLED;
    endcase
  end

  assign go       = (state_q == ST_IDLE) && (state_nxt == ST_HS_RQST);
  assign mask_nxt = go ? lane_mask : mask_s;

  // RQST is only ever entered on go, so it loads the live lpx value.
  always_comb begin
    load_val = '0;
    case (state_nxt)
      ST_HS_RQST:  load_val = go ? cfg_t_lpx : lpx_s;
      ST_HS_PREP:  load_val = prep_s;
      ST_HS_ZERO:  load_val = zero_s;
      ST_HS_TRAIL: load_val = trail_s;
      ST_HS_EXIT:  load_val = exit_s;
      default:     load_val = '0;
    endcase
  end

  dsi_dwell_timer #(.CNT_W(CNT_W)) u_dwell (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .load    (state_nxt != state_q),
    .en      (is_timed(state_q)),
    .load_val(load_val),
    .done    (dwell_done)
  );

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      lpx_s   <= CNT_W'(T_LPX);
      prep_s  <= CNT_W'(T_HS_PREP);
      zero_s  <= CNT_W'(T_HS_ZERO);
      trail_s <= CNT_W'(T_HS_TRAIL);
      exit_s  <= CNT_W'(T_HS_EXIT);
      mask_s  <= '0;
    end else if (go) begin
      lpx_s   <= cfg_t_lpx;
      prep_s  <= cfg_t_prep;
      zero_s  <= cfg_t_zero;
      trail_s <= cfg_t_trail;
      exit_s  <= cfg_t_exit;
      mask_s  <= lane_mask;
    end
  end

  // Finish request is remembered from RQST through ACTIVE and dropped at burst end.
  assign fin_nxt = (state_nxt inside {ST_IDLE, ST_DISABLED}) ? 1'b0 :
                   fin_q | (fin_rqst &&
                   (state_q inside {ST_HS_RQST, ST_HS_PREP, ST_HS_ZERO, ST_HS_ACTIVE}));

`ifdef DSI_LANE_HS_WDT_EN
  logic [WDT_W-1:0] wdt_cnt, wdt_s;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wdt_cnt <= '0;
      wdt_s   <= '0;
    end else begin
      if (go) wdt_s <= cfg_t_wdt;
      if (state_nxt == ST_HS_ACTIVE && state_q != ST_HS_ACTIVE) wdt_cnt <= WDT_W'(1);
      else if (state_q == ST_HS_ACTIVE && wdt_cnt != '1)       wdt_cnt <= wdt_cnt + WDT_W'(1);
    end
  end

  // wdt_cnt holds the 1-based ACTIVE cycle number; a limit of 0 disables it.
  assign wdt_to = (state_q == ST_HS_ACTIVE) && (wdt_s != '0) &&
                  (wdt_cnt == wdt_s) && !hs_fin_ack;
`else
  logic unused_wdt;
  assign unused_wdt = ^cfg_t_wdt;
  assign wdt_to     = 1'b0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign drv_nxt[i] = lane_drive(state_nxt, mask_nxt[i]);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_DISABLED;
      fin_q    <= 1'b0;
      hs_start <= 1'b0;
      hs_fin   <= 1'b0;
      busy     <= 1'b0;
      err_wdt  <= 1'b0;
      lp_p     <= '1;
      lp_n     <= '1;
      lp_oe    <= '0;
      hs_en    <= '0;
    end else begin
      state_q  <= state_nxt;
      fin_q    <= fin_nxt;
      hs_start <= (state_q == ST_HS_ZERO) && (state_nxt == ST_HS_ACTIVE);
      hs_fin   <= (state_nxt == ST_HS_ACTIVE) && fin_nxt;
      busy     <= !(state_nxt inside {ST_DISABLED, ST_IDLE});
      err_wdt  <= wdt_to;
      for (int i = 0; i < LANES; i++) begin
        lp_p[i]  <= drv_nxt[i].p;
        lp_n[i]  <= drv_nxt[i].n;
        lp_oe[i] <= drv_nxt[i].oe;
        hs_en[i] <= drv_nxt[i].hs;
      end
    end
  end

endmodule

// File: tb/tb_dsi_lane_seq_multi.sv
// Directed bench for dsi_lane_seq_multi: dwell lengths, masking, shadowing,
// lines_enable drop, async reset, zero dwells and (if enabled) the watchdog.
module tb_dsi_lane_seq_multi;

  localparam int LANES = 4;
  localparam int CNT_W = 8;
  localparam int WDT_W = 16;
  localparam int PH_RQST = 0, PH_PREP = 1, PH_HS = 2, PH_EXIT = 3, PH_IDLE = 4;

  logic clk_sys = 1'b0;
  logic rst_n, lines_enable, start_rqst, fin_rqst, hs_fin_ack;
  logic [LANES-1:0] lane_mask;
  logic [CNT_W-1:0] cfg_t_lpx, cfg_t_prep, cfg_t_zero, cfg_t_trail, cfg_t_exit;
  logic [WDT_W-1:0] cfg_t_wdt;
  logic hs_start, hs_fin, busy, err_wdt;
  logic [LANES-1:0] hs_en, lp_p, lp_n, lp_oe;

  int n_assert = 0;
  int n_fail   = 0;
  bit mon_on   = 1'b0;
  int mon_bad  = 0;

  dsi_lane_seq_multi #(.LANES(LANES), .CNT_W(CNT_W), .WDT_W(WDT_W)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .lines_enable(lines_enable),
    .start_rqst(start_rqst), .fin_rqst(fin_rqst), .lane_mask(lane_mask),
    .cfg_t_lpx(cfg_t_lpx), .cfg_t_prep(cfg_t_prep), .cfg_t_zero(cfg_t_zero),
    .cfg_t_trail(cfg_t_trail), .cfg_t_exit(cfg_t_exit), .cfg_t_wdt(cfg_t_wdt),
    .hs_fin_ack(hs_fin_ack), .hs_start(hs_start), .hs_fin(hs_fin),
    .hs_en(hs_en), .lp_p(lp_p), .lp_n(lp_n), .lp_oe(lp_oe),
    .busy(busy), .err_wdt(err_wdt)
  );

  always #5 clk_sys = ~clk_sys;

  // Lanes 1 and 3 must sit at LP-11/oe=1; lane 2 must mirror lane 0.
  always @(negedge clk_sys) begin
    if (mon_on && busy) begin
      if (lp_oe[1] !== 1'b1 || lp_p[1] !== 1'b1 || lp_n[1] !== 1'b1 || hs_en[1] !== 1'b0 ||
          lp_oe[3] !== 1'b1 || lp_p[3] !== 1'b1 || lp_n[3] !== 1'b1 || hs_en[3] !== 1'b0 ||
          lp_p[2] !== lp_p[0] || lp_n[2] !== lp_n[0] ||
          lp_oe[2] !== lp_oe[0] || hs_en[2] !== hs_en[0])
        mon_bad++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit in_phase(input int ph, input int r);
    case (ph)
      PH_RQST: return busy && lp_oe[r] && !lp_p[r] &&  lp_n[r];
      PH_PREP: return busy && lp_oe[r] && !lp_p[r] && !lp_n[r];
      PH_HS:   return hs_en[r] && !lp_oe[r] && !hs_start;
      PH_EXIT: return busy && lp_oe == '1 && lp_p == '1 && lp_n == '1 && hs_en == '0;
      default: return !busy && lp_oe == '1;
    endcase
  endfunction

  // Waits (bounded) for a phase, then counts how many cycles it lasts.
  task automatic measure(input string tag, input int ph, input int r, input int exp);
    int w = 0;
    int n = 0;
    while (!in_phase(ph, r) && w < 60) begin @(negedge clk_sys); w++; end
    while (in_phase(ph, r) && n < 60) begin n++; @(negedge clk_sys); end
    check(tag, n, exp);
  endtask

  task automatic set_cfg(input int lpx, input int prep, input int zero,
                         input int trail, input int ext);
    cfg_t_lpx   = CNT_W'(lpx);
    cfg_t_prep  = CNT_W'(prep);
    cfg_t_zero  = CNT_W'(zero);
    cfg_t_trail = CNT_W'(trail);
    cfg_t_exit  = CNT_W'(ext);
  endtask

  // Called in the hs_start cycle: ack for one cycle, then time TRAIL and EXIT.
  task automatic ack_and_close(input string t, input int e_trail, input int e_exit);
    hs_fin_ack = 1'b1;
    @(negedge clk_sys);
    hs_fin_ack = 1'b0;
    measure({t, "_trail"}, PH_HS, 0, e_trail);
    measure({t, "_exit"}, PH_EXIT, 0, e_exit);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; lines_enable = 1'b0; start_rqst = 1'b0; fin_rqst = 1'b0;
    hs_fin_ack = 1'b0; lane_mask = '1; cfg_t_wdt = '0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk_sys);

    // reset values
    check("rst_lp_oe", lp_oe, 0);
    check("rst_hs_en", hs_en, 0);
    check("rst_lp_pn", {lp_p, lp_n}, 8'hFF);
    check("rst_flags", {hs_start, hs_fin, busy, err_wdt}, 0);
    rst_n = 1'b1;
    @(negedge clk_sys);
    check("disabled_oe", lp_oe, 0);
    lines_enable = 1'b1;
    @(negedge clk_sys);
    check("idle_oe", lp_oe, 4'hF);

    // 1: basic burst
    set_cfg(3, 2, 4, 2, 3);
    lane_mask = 4'b1111; start_rqst = 1'b1; fin_rqst = 1'b1;
    measure("t1_rqst", PH_RQST, 0, 4);
    start_rqst = 1'b0;
    measure("t1_prep", PH_PREP, 0, 3);
    measure("t1_zero", PH_HS, 0, 5);
    check("t1_hs_start", hs_start, 1);
    check("t1_hs_fin", hs_fin, 1);
    fin_rqst = 1'b0;
    @(negedge clk_sys);
    check("t1_start_pulse", hs_start, 0);
    repeat (8) @(negedge clk_sys);
    check("t1_active_hold", {busy, hs_en, hs_fin}, 6'b1_1111_1);
    @(negedge clk_sys);
    hs_fin_ack = 1'b1;
    @(negedge clk_sys);
    hs_fin_ack = 1'b0;
    check("t1_fin_clr", hs_fin, 0);
    measure("t1_trail", PH_HS, 0, 3);
    measure("t1_exit", PH_EXIT, 0, 4);
    check("t1_idle", {busy, lp_oe, lp_p, lp_n}, 13'b0_1111_1111_1111);

    // 2: partial mask, fin_rqst pulsed in ACTIVE
    lane_mask = 4'b0101; start_rqst = 1'b1; mon_on = 1'b1;
    measure("t2_rqst", PH_RQST, 0, 4);
    start_rqst = 1'b0; lane_mask = 4'b1111;
    measure("t2_prep", PH_PREP, 0, 3);
    measure("t2_zero", PH_HS, 0, 5);
    check("t2_hs_en", hs_en, 4'b0101);
    check("t2_no_fin", hs_fin, 0);
    fin_rqst = 1'b1;
    @(negedge clk_sys);
    fin_rqst = 1'b0;
    check("t2_fin_sticky", hs_fin, 1);
    ack_and_close("t2", 3, 4);
    mon_on = 1'b0;
    check("t2_masked_lanes", mon_bad, 0);

    // 3: cfg change mid-burst only affects the next burst
    start_rqst = 1'b1;
    measure("t3_rqst_a", PH_RQST, 0, 4);
    start_rqst = 1'b0;
    cfg_t_lpx = 8'd9; cfg_t_trail = 8'd7;
    measure("t3_prep_a", PH_PREP, 0, 3);
    measure("t3_zero_a", PH_HS, 0, 5);
    ack_and_close("t3a", 3, 4);
    start_rqst = 1'b1;
    measure("t3_rqst_b", PH_RQST, 0, 10);
    start_rqst = 1'b0;
    measure("t3_prep_b", PH_PREP, 0, 3);
    measure("t3_zero_b", PH_HS, 0, 5);
    ack_and_close("t3b", 8, 4);

    // 4: lines_enable drops mid-burst
    set_cfg(3, 2, 4, 2, 3);
    start_rqst = 1'b1;
    measure("t4_rqst", PH_RQST, 0, 4);
    start_rqst = 1'b0;
    measure("t4_prep", PH_PREP, 0, 3);
    measure("t4_zero", PH_HS, 0, 5);
    lines_enable = 1'b0;
    repeat (3) @(negedge clk_sys);
    check("t4_still_active", {busy, hs_en}, 5'b1_1111);
    ack_and_close("t4", 3, 4);
    measure("t4_idle", PH_IDLE, 0, 1);
    check("t4_disabled", {busy, lp_oe, hs_en}, 0);
    lines_enable = 1'b1;
    @(negedge clk_sys);
    check("t4_reenable", {busy, lp_oe}, 5'b0_1111);

    // 5: async reset in HS_ZERO
    start_rqst = 1'b1;
    measure("t5_rqst", PH_RQST, 0, 4);
    start_rqst = 1'b0;
    measure("t5_prep", PH_PREP, 0, 3);
    check("t5_in_zero", hs_en, 4'hF);
    #2 rst_n = 1'b0;
    lines_enable = 1'b0;
    #1;
    check("t5_async_rst", {hs_en, lp_oe, lp_p, lp_n, busy, hs_start, hs_fin, err_wdt},
          {4'h0, 4'h0, 4'hF, 4'hF, 4'h0});
    @(negedge clk_sys);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    check("t5_disabled", {busy, lp_oe}, 0);
    lines_enable = 1'b1;
    @(negedge clk_sys);
    check("t5_idle", {busy, lp_oe}, 5'b0_1111);

    // 6: zero dwells; start_rqst held relaunches after EXIT
    set_cfg(0, 0, 0, 0, 0);
    cfg_t_wdt = 16'd20;
    start_rqst = 1'b1;
    measure("t6_rqst", PH_RQST, 0, 1);
    measure("t6_prep", PH_PREP, 0, 1);
    measure("t6_zero", PH_HS, 0, 1);
    check("t6_hs_start", hs_start, 1);
    ack_and_close("t6", 1, 1);
    measure("t6_relaunch_rqst", PH_RQST, 0, 1);
    start_rqst = 1'b0;
    measure("t6_relaunch_prep", PH_PREP, 0, 1);
    measure("t6_relaunch_zero", PH_HS, 0, 1);
`ifdef DSI_LANE_HS_WDT_EN
    fin_rqst = 1'b1;
    n = 0;
    while (!err_wdt && n < 100) begin n++; @(negedge clk_sys); end
    fin_rqst = 1'b0;
    check("t6_wdt_cycles", n, 20);
    check("t6_wdt_trail", {hs_fin, hs_en}, 5'b0_1111);
    @(negedge clk_sys);
    check("t6_wdt_pulse", err_wdt, 0);
    measure("t6_wdt_exit", PH_EXIT, 0, 1);
`else
    n = 0;
    repeat (30) begin
      @(negedge clk_sys);
      if (err_wdt) n++;
    end
    check("t6_no_wdt", n, 0);
    check("t6_wait_active", {busy, hs_en}, 5'b1_1111);
    ack_and_close("t6_end", 1, 1);
`endif
    check("t6_idle", {busy, lp_oe}, 5'b0_1111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
